// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and PS/2 pad signals of the host transmitter.
// tx_valid/tx_ready: a byte is taken on the rising clk edge where both are high; tx_data must be stable while tx_valid is high.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [2:0] state_dbg;

    modport slave (
        input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe, state_dbg
    );

    modport master (
        output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe, state_dbg
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB-first,
// odd parity, stop, then device ACK check with an overall timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input logic          clk,
    input logic          rst,
    ps2_host_tx_if.slave bus
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [8:0]    sh, sh_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;

    // Synchronisers idle high so a reset never looks like a falling edge.
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       sync_clk, sync_data, fall, timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], bus.ps2_clk_in};
            data_sync <= {data_sync[0], bus.ps2_data_in};
        end
    end

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];
    assign fall      = clk_sync[2] & ~clk_sync[1];
    assign timeout   = (cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_cnt   <= bit_cnt_d;
            sh        <= sh_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        sh_d      = sh;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        case (state)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    sh_d      = {~^bus.tx_data, bus.tx_data};
                    clk_oe_d  = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt == INH_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                clk_oe_d = 1'b0;
                cnt_d    = cnt + CW'(1);
                // Timeout is checked ahead of the falling edge so it wins a tie.
                if (timeout) begin
                    data_oe_d = 1'b0;
                    state_d   = S_ERR;
                end else if (state == S_SHIFT) begin
                    if (fall) begin
                        bit_cnt_d = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            data_oe_d = 1'b0;
                            state_d   = S_ACK;
                        end else begin
                            data_oe_d = ~sh[0];
                            sh_d      = {1'b0, sh[8:1]};
                        end
                    end
                end else if (state == S_ACK) begin
                    data_oe_d = 1'b0;
                    if (fall) begin
                        state_d = sync_data ? S_ERR : S_WAIT_IDLE;
                    end
                end else begin
                    data_oe_d = 1'b0;
                    if (sync_clk && sync_data) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE, S_ERR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign bus.tx_ready    = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.tx_done     = (state == S_DONE);
    assign bus.tx_err      = (state == S_ERR);
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.state_dbg   = state;

endmodule
